// File: rtl/spi_frame_slave.sv
// SPI frame slave: receives a FRAME_W-bit command MSB-first and then returns a RESP_W-bit response.
// Latency: rx_frame/rx_valid update 1 clk after the synchronized final sample edge (SYNC_STAGES+1 clk after the pin).
// Backpressure: none. The SPI master sets the pace, and tx_load may be applied at any time.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sclk, cs_n, mosi    SPI inputs (asynchronous to clk)
//   miso, miso_oe       serial response and its tristate enable
//   rx_frame, rx_valid  last complete command and its one-clk update strobe
//   tx_data, tx_load    response word and the strobe that loads it into the holding register
//   tx_stale            holding register not reloaded since it was last sent
//   abort_cnt           saturating count of frames cut short by cs_n
module spi_frame_slave #(
   parameter int FRAME_W     = 24,
   parameter int RESP_W      = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sclk,
   input  logic               cs_n,
   input  logic               mosi,
   output logic               miso,
   output logic               miso_oe,
   output logic [FRAME_W-1:0] rx_frame,
   output logic               rx_valid,
   input  logic [RESP_W-1:0]  tx_data,
   input  logic               tx_load,
   output logic               tx_stale,
   output logic [7:0]         abort_cnt
);

   localparam int RX_CNT_W = $clog2(FRAME_W + 1);
   localparam int TX_CNT_W = $clog2(RESP_W + 1);
   localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(FRAME_W - 1);
   localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(RESP_W - 1);
   localparam logic [2:0] FILL_N = 3'(SYNC_STAGES);
   localparam logic SCLK_IDLE = (CPOL != 0);

   typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic sclk_prev_q, sclk_prev_d;
   logic cs_prev_q, cs_prev_d;
   logic [2:0] fill_q, fill_d;
   logic cs_armed_q, cs_armed_d;
   logic [FRAME_W-2:0] rx_shift_q, rx_shift_d;
   logic [RX_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [FRAME_W-1:0] rx_frame_q, rx_frame_d;
   logic rx_valid_q, rx_valid_d;
   logic [RESP_W-1:0] hold_q, hold_d;
   logic tx_stale_q, tx_stale_d;
   logic [RESP_W-1:0] tx_shift_q, tx_shift_d;
   logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic miso_bit_q, miso_bit_d;
   logic [7:0] abort_cnt_q, abort_cnt_d;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic cs_fall, rx_done, tx_done, abort;
   logic [FRAME_W-1:0] rx_word;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
   assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
   assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
   assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

   // The synchronizers come out of reset holding preset values rather than samples.
   // A falling cs_n is therefore accepted only after cs_n has really been seen high.
   // This prevents a frame that began during reset from being picked up halfway through.
   assign cs_fall = cs_armed_q & cs_prev_q & ~cs_s;
   assign rx_done = (state_q == RX) & ~cs_s & sample_edge & (rx_cnt_q == RX_LAST);
   assign tx_done = (state_q == TX) & ~cs_s & sample_edge & (tx_cnt_q == TX_LAST);
   assign abort   = cs_s & ((state_q == RX) | (state_q == TX));
   assign rx_word = {rx_shift_q, mosi_s};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (cs_s) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (cs_fall) state_d = RX;
            RX:      if (rx_done) state_d = TX;
            TX:      if (tx_done) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   // Outputs: miso is driven only while the response is being shifted out.
   always_comb begin
      miso    = (state_q == TX) ? miso_bit_q : 1'b0;
      miso_oe = (state_q != IDLE);
   end

   // Datapath
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
      fill_d      = (fill_q == FILL_N) ? fill_q : fill_q + 3'd1;
      cs_armed_d  = cs_armed_q | ((fill_q == FILL_N) & cs_s);
      rx_shift_d  = rx_shift_q;
      rx_cnt_d    = rx_cnt_q;
      rx_frame_d  = rx_frame_q;
      rx_valid_d  = 1'b0;
      hold_d      = hold_q;
      tx_stale_d  = tx_stale_q;
      tx_shift_d  = tx_shift_q;
      tx_cnt_d    = tx_cnt_q;
      miso_bit_d  = miso_bit_q;
      abort_cnt_d = abort_cnt_q;

      if (state_q == IDLE || cs_s) begin
         // Any partial frame is discarded when the FSM idles or cs_n is released.
         rx_shift_d = '0;
         rx_cnt_d   = '0;
         tx_cnt_d   = '0;
         miso_bit_d = 1'b0;
      end else if (state_q == RX && sample_edge) begin
         rx_shift_d = rx_word[FRAME_W-2:0];
         rx_cnt_d   = rx_cnt_q + RX_CNT_W'(1);
         if (rx_cnt_q == RX_LAST) begin
            rx_frame_d = rx_word;
            rx_valid_d = 1'b1;
            tx_shift_d = hold_q;
            tx_stale_d = 1'b1;
            tx_cnt_d   = '0;
            miso_bit_d = 1'b0;
         end
      end else if (state_q == TX) begin
         if (shift_edge) begin
            miso_bit_d = tx_shift_q[RESP_W-1];
            tx_shift_d = tx_shift_q << 1;
         end
         if (sample_edge) begin
            tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
         end
      end

      if (abort && abort_cnt_q != 8'hFF) begin
         abort_cnt_d = abort_cnt_q + 8'd1;
      end

      // This comes after the frame-completion copy. On a same-clk collision the old word
      // has already been taken for sending, and the new word remains fresh.
      if (tx_load) begin
         hold_d     = tx_data;
         tx_stale_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         mosi_sync_q <= '0;
         sclk_prev_q <= SCLK_IDLE;
         cs_prev_q   <= 1'b1;
         fill_q      <= '0;
         cs_armed_q  <= 1'b0;
         rx_shift_q  <= '0;
         rx_cnt_q    <= '0;
         rx_frame_q  <= '0;
         rx_valid_q  <= 1'b0;
         hold_q      <= '0;
         tx_stale_q  <= 1'b1;
         tx_shift_q  <= '0;
         tx_cnt_q    <= '0;
         miso_bit_q  <= 1'b0;
         abort_cnt_q <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         fill_q      <= fill_d;
         cs_armed_q  <= cs_armed_d;
         rx_shift_q  <= rx_shift_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_frame_q  <= rx_frame_d;
         rx_valid_q  <= rx_valid_d;
         hold_q      <= hold_d;
         tx_stale_q  <= tx_stale_d;
         tx_shift_q  <= tx_shift_d;
         tx_cnt_q    <= tx_cnt_d;
         miso_bit_q  <= miso_bit_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign rx_frame  = rx_frame_q;
   assign rx_valid  = rx_valid_q;
   assign tx_stale  = tx_stale_q;
   assign abort_cnt = abort_cnt_q;

endmodule

// File: doc/spi_frame_slave.md
SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 Parameter FRAME_W, default 24: command frame length in bits, received MSB-first; legal range 8..64.
REQ-002 Parameter RESP_W, default 8: response length in bits, transmitted MSB-first; legal range 1..32.
REQ-003 Parameter CPOL, default 0: SCLK idle level.
REQ-004 Parameter CPHA, default 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
REQ-005 Parameter SYNC_STAGES, default 2: flop stages on sclk, cs_n and mosi; legal range 2..4.
REQ-006 Port clk, input, 1: system clock; all logic is single-domain on posedge clk.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port sclk, input, 1: SPI clock, asynchronous to clk.
REQ-009 Port cs_n, input, 1: chip select, active-low, asynchronous.
REQ-010 Port mosi, input, 1: serial data from master.
REQ-011 Port miso, output, 1: serial response data.
REQ-012 Port miso_oe, output, 1: tristate enable for miso; high while a frame is active.
REQ-013 Port rx_frame, output, FRAME_W: last complete command frame.
REQ-014 Port rx_valid, output, 1: one-clk pulse when rx_frame updates.
REQ-015 Port tx_data, input, RESP_W: response word.
REQ-016 Port tx_load, input, 1: one-clk strobe that captures tx_data into the response holding register.
REQ-017 Port tx_stale, output, 1: response holding register has not been reloaded since the last response was sent.
REQ-018 Port abort_cnt, output, 8: saturating count of aborted frames.

Function
REQ-019 Edge detection uses the last two synchronized sclk values: sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Leading edge = rise if CPOL=0, fall if CPOL=1.
REQ-020 Supported sclk period is at least 8 clk periods, with each phase lasting at least 3 clk periods.
REQ-021 FSM states: IDLE, RX, TX, DONE.
  - IDLE->RX on synchronized cs_n falling.
  - RX->TX on the FRAME_W-th sample edge.
  - TX->DONE on the RESP_W-th sample edge counted within TX.
  - Any state->IDLE on synchronized cs_n high.
REQ-022 In RX, each sample edge shifts synchronized mosi into the LSB of the shift register. A bit counter of width clog2(FRAME_W+1) increments on each sample edge.
REQ-023 On the FRAME_W-th sample edge:
  - rx_frame is loaded with the completed word, including the final bit, in the following clk cycle.
  - rx_valid pulses high for exactly 1 clk in that same cycle.
  - rx_frame holds until the next completed frame.
REQ-024 On the same edge, the holding register is copied into the TX shift register and tx_stale is set to 1.
REQ-025 In TX:
  - The first shift edge after the RX->TX transition drives the response MSB on miso.
  - Each later shift edge drives the next lower bit.
  - Sample edges count the transmitted bits.
REQ-026 In IDLE and DONE, miso = 0. Further sclk edges in DONE are ignored, and no second frame starts until cs_n goes high.
REQ-027 miso_oe = 1 in RX, TX and DONE; 0 in IDLE.
REQ-028 tx_load writes the holding register and clears tx_stale. If tx_load and the RX-completion copy occur in the same clk, the old holding value is sent and the new value is kept with tx_stale = 0.
REQ-029 Abort: cs_n high while in RX or TX:
  - the partial frame is discarded and rx_valid does not pulse;
  - counters are cleared;
  - abort_cnt increments, saturating at 255.
  cs_n high in DONE is a normal end of frame.
REQ-030 A frame whose cs_n asserts while rst_n is low is ignored; the FSM waits in IDLE for the next cs_n falling edge.

Reset
REQ-031 While rst_n is low:
  - state = IDLE;
  - rx_frame = 0, rx_valid = 0;
  - miso = 0, miso_oe = 0;
  - holding and shift registers = 0;
  - tx_stale = 1, abort_cnt = 0;
  - synchronizers preset to the idle levels (cs_n = 1, sclk = CPOL).
REQ-032 Reset asserted mid-frame returns the block to the REQ-031 values immediately, with no rx_valid pulse.

Verification
REQ-033 Mode 0 defaults, tx_load with tx_data = 0xA5, then a 24-bit frame 0x3C5A81 followed by 8 clocks:
  - rx_frame = 0x3C5A81 with a single rx_valid pulse;
  - miso returns 10100101;
  - tx_stale = 1 afterwards.
REQ-034 Repeat REQ-033 for CPOL/CPHA = 01, 10 and 11: identical rx_frame and miso bit sequence in every mode.
REQ-035 cs_n raised after 13 bits: no rx_valid, abort_cnt = 1, miso_oe = 0. The next full frame 0x000001 is received correctly.
REQ-036 FRAME_W = 32, RESP_W = 16, holding register 0xBEEF, frame 0xDEADBEEF: rx_frame = 0xDEADBEEF and miso returns 0xBEEF. With no reload, a second frame returns 0xBEEF again and tx_stale stays 1.
REQ-037 tx_load (0x5A) in the same clk as RX completion with prior holding value 0x11: 0x11 is sent. The next frame sends 0x5A, and tx_stale = 0 between the two frames.
REQ-038 Twenty extra sclk pulses after the response: miso stays 0 and there is no extra rx_valid. 300 aborts give abort_cnt = 255.
